// File: rtl/nvm_arb_pkg.sv
// Shared types and helpers for the NVM program-memory arbiter and write sequencer.
package nvm_arb_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_PGM,
        S_GAP,
        S_VFY,
        S_ACK
    } nvm_state_t;

    localparam int NVM_PULSE_MAX = 8;
    localparam int NVM_PLS_W     = $clog2(NVM_PULSE_MAX);
    localparam int NVM_DW_MAX    = 32;

    // OTP cells only ever gain set bits, so extra set bits in the read-back are not a failure.
    function automatic logic nvm_vfy_ok(input logic [NVM_DW_MAX-1:0] dout,
                                        input logic [NVM_DW_MAX-1:0] wdata);
        return (dout & wdata) == wdata;
    endfunction

endpackage

// File: rtl/nvm_cyc_tmr.sv
// Loadable down-counter timing the RD/PGM/GAP/VFY phases; done is high while the count is zero.
module nvm_cyc_tmr #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    output logic          done
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/nvm_arb.sv
// Arbitrates the NVM port between CPU fetch and host bridge; sequences host writes as pulse/gap/verify.
// Optional build macro NVM_MULTI_PULSE_EN enables programming retries up to cfg_npls+1 pulses.
module nvm_arb
    import nvm_arb_pkg::*;
#(
    parameter int AW      = 14,
    parameter int DW      = 8,
    parameter int RD_CYC  = 2,
    parameter int PW_CYC  = 16,
    parameter int GAP_CYC = 4
) (
    input  logic          clk,
    input  logic          srst,
    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_addr,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          hst_req,
    input  logic          hst_we,
    input  logic [AW-1:0] hst_addr,
    input  logic [DW-1:0] hst_wdata,
    output logic [DW-1:0] hst_rdata,
    output logic          hst_ack,
    output logic          hst_fail,
    input  logic          cfg_mpls,
    input  logic [2:0]    cfg_npls,
    output logic [AW-1:0] nvm_a,
    output logic          nvm_re,
    output logic          nvm_pgm,
    output logic [DW-1:0] nvm_din,
    input  logic [DW-1:0] nvm_dout,
    output logic          busy
);

    localparam int MAXC = (PW_CYC > GAP_CYC) ? ((PW_CYC > RD_CYC) ? PW_CYC : RD_CYC)
                                             : ((GAP_CYC > RD_CYC) ? GAP_CYC : RD_CYC);
    localparam int CW   = $clog2(MAXC + 1);

    nvm_state_t    state, state_n;
    logic          sel_hst;
    logic          last_hst;
    logic          fail_q;
    logic          grant, grant_hst;
    logic          tmr_load, tmr_done;
    logic [CW-1:0] tmr_val;
    logic          vfy_pass;
    logic          can_retry;

    nvm_cyc_tmr #(.CW(CW)) u_tmr (
        .clk      (clk),
        .srst     (srst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    // nvm_din holds the latched write data for the whole operation, so verify compares against it.
    assign vfy_pass = nvm_vfy_ok(NVM_DW_MAX'(nvm_dout), NVM_DW_MAX'(nvm_din));

`ifdef NVM_MULTI_PULSE_EN
    logic [NVM_PLS_W-1:0] pls_cnt;
    logic [NVM_PLS_W-1:0] pls_lim;
    logic                 retry;

    assign can_retry = (pls_cnt != pls_lim);

    always_ff @(posedge clk) begin
        if (srst) begin
            pls_cnt <= '0;
            pls_lim <= '0;
        end else if (grant) begin
            pls_cnt <= '0;
            pls_lim <= cfg_mpls ? NVM_PLS_W'(cfg_npls) : '0;
        end else if (retry) begin
            pls_cnt <= pls_cnt + 1'b1;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{cfg_mpls, cfg_npls};
    assign can_retry  = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        grant     = 1'b0;
        grant_hst = 1'b0;
        tmr_load  = 1'b0;
        tmr_val   = '0;
`ifdef NVM_MULTI_PULSE_EN
        retry     = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (cpu_req || hst_req) begin
                    grant     = 1'b1;
                    // On a tie the side not served last wins.
                    grant_hst = hst_req && (!cpu_req || !last_hst);
                    tmr_load  = 1'b1;
                    if (grant_hst && hst_we) begin
                        state_n = S_PGM;
                        tmr_val = CW'(PW_CYC - 1);
                    end else begin
                        state_n = S_RD;
                        tmr_val = CW'(RD_CYC - 1);
                    end
                end
            end
            S_RD: begin
                if (tmr_done) state_n = S_ACK;
            end
            S_PGM: begin
                if (tmr_done) begin
                    state_n  = S_GAP;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(GAP_CYC - 1);
                end
            end
            S_GAP: begin
                if (tmr_done) begin
                    state_n  = S_VFY;
                    tmr_load = 1'b1;
                    tmr_val  = CW'(RD_CYC - 1);
                end
            end
            S_VFY: begin
                if (tmr_done) begin
                    if (!vfy_pass && can_retry) begin
                        state_n  = S_PGM;
                        tmr_load = 1'b1;
                        tmr_val  = CW'(PW_CYC - 1);
`ifdef NVM_MULTI_PULSE_EN
                        retry    = 1'b1;
`endif
                    end else begin
                        state_n = S_ACK;
                    end
                end
            end
            S_ACK:   state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state     <= S_IDLE;
            last_hst  <= 1'b1;
            fail_q    <= 1'b0;
            cpu_rdata <= '0;
            cpu_ack   <= 1'b0;
            hst_rdata <= '0;
            hst_ack   <= 1'b0;
            hst_fail  <= 1'b0;
            nvm_a     <= '0;
            nvm_re    <= 1'b0;
            nvm_pgm   <= 1'b0;
            nvm_din   <= '0;
            busy      <= 1'b0;
        end else begin
            state   <= state_n;
            // Strobes follow the next state so they line up exactly with the phase.
            nvm_re  <= (state_n == S_RD) || (state_n == S_VFY);
            nvm_pgm <= (state_n == S_PGM);
            busy    <= (state_n != S_IDLE);
            cpu_ack <= (state == S_ACK) && !sel_hst;
            hst_ack <= (state == S_ACK) && sel_hst;

            if (grant) begin
                last_hst <= grant_hst;
                nvm_a    <= grant_hst ? hst_addr : cpu_addr;
                hst_fail <= 1'b0;
                fail_q   <= 1'b0;
                if (grant_hst && hst_we) nvm_din <= hst_wdata;
            end

            if (state == S_RD && tmr_done) begin
                if (sel_hst) hst_rdata <= nvm_dout;
                else         cpu_rdata <= nvm_dout;
            end

            if (state == S_VFY && tmr_done) begin
                hst_rdata <= nvm_dout;
                fail_q    <= !vfy_pass;
            end

            if (state == S_ACK && sel_hst) hst_fail <= fail_q;
        end
    end

    // Requester select is only consulted once an operation has been granted.
    always_ff @(posedge clk) begin
        if (grant) sel_hst <= grant_hst;
    end

endmodule
